// File: rtl/sfft_frame_reader.sv
// ============================================================================
//  Module   : sfft_frame_reader
//  Brief    : Reads one spectrum frame from a byte-wide accelerator slave.
//             Sets the sample lock, checks the status byte, optionally reads
//             the frame timer, then streams N_BINS little-endian 32-bit bins
//             out over a valid/ready handshake and finally clears the lock.
//  Options  : define SFFT_READER_TIMESTAMP_EN to read the 4 timer bytes into
//             frame_time; when undefined the timer is skipped and
//             frame_time is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfft_frame_reader #(
    parameter int  N_BINS      = 256,
    parameter int  STATUS_ADDR = 4*N_BINS+4,
    localparam int IDX_W       = (N_BINS > 1) ? $clog2(N_BINS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             chipselect,
    output logic             write,
    output logic             read,
    output logic [15:0]      address,
    output logic [7:0]       writedata,
    input  logic [7:0]       readdata,
    output logic [31:0]      out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      frame_time,
    output logic             busy,
    output logic             done,
    output logic             error
);

    // Bus addresses and control bytes
    localparam logic [15:0]      c_CTRL_ADDR   = 16'h0000;
    localparam logic [15:0]      c_TIMER_ADDR  = 16'(4*N_BINS);
    localparam logic [15:0]      c_STATUS_ADDR = 16'(STATUS_ADDR);
    localparam logic [7:0]       c_LOCK_SET    = 8'h01;
    localparam logic [7:0]       c_LOCK_CLR    = 8'h00;
    localparam logic [IDX_W-1:0] c_LAST_BIN    = IDX_W'(N_BINS-1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOCK    = 3'd1,
        ST_STATUS  = 3'd2,
`ifdef SFFT_READER_TIMESTAMP_EN
        ST_TIME    = 3'd3,
`endif
        ST_BINS    = 3'd4,
        ST_EMIT    = 3'd5,
        ST_RELEASE = 3'd6
    } state_t;

    // State after a good status byte depends on whether the timer is read
`ifdef SFFT_READER_TIMESTAMP_EN
    localparam state_t c_AFTER_STATUS = ST_TIME;
`else
    localparam state_t c_AFTER_STATUS = ST_BINS;
`endif

    state_t           r_state;
    state_t           w_next_state;

    logic             r_phase;       // 0 = ISSUE cycle, 1 = CAPTURE cycle
    logic [1:0]       r_byte;        // byte offset within the current word
    logic [IDX_W-1:0] r_bin;         // current bin number
    logic [31:0]      r_word;        // bin word being assembled / presented
    logic             r_status_ok;   // status bit0 of the current frame
    logic             r_post_reset;  // the pending RELEASE is the reset cleanup
    logic             r_done;
    logic             r_error;

    logic             w_cs;
    logic             w_rd;
    logic             w_wr;
    logic [15:0]      w_addr;
    logic [7:0]       w_wdata;
    logic             w_last_byte;
    logic             w_last_bin;
    logic             w_handshake;

    assign w_last_byte = (r_byte == 2'd3);
    assign w_last_bin  = (r_bin == c_LAST_BIN);
    assign w_handshake = (r_state == ST_EMIT) && out_ready;

    // State register; reset parks in RELEASE so a stale lock gets cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RELEASE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and bus drive for the current state
    always_comb begin
        w_next_state = r_state;
        w_cs         = 1'b0;
        w_rd         = 1'b0;
        w_wr         = 1'b0;
        w_addr       = c_CTRL_ADDR;
        w_wdata      = c_LOCK_CLR;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_LOCK;
                end
            end
            ST_LOCK: begin
                w_cs         = 1'b1;
                w_wr         = 1'b1;
                w_addr       = c_CTRL_ADDR;
                w_wdata      = c_LOCK_SET;
                w_next_state = ST_STATUS;
            end
            ST_STATUS: begin
                w_cs   = 1'b1;
                w_rd   = 1'b1;
                w_addr = c_STATUS_ADDR;
                if (r_phase) begin
                    w_next_state = readdata[0] ? c_AFTER_STATUS : ST_RELEASE;
                end
            end
`ifdef SFFT_READER_TIMESTAMP_EN
            ST_TIME: begin
                w_cs   = 1'b1;
                w_rd   = 1'b1;
                w_addr = c_TIMER_ADDR + {14'd0, r_byte};
                if (r_phase && w_last_byte) begin
                    w_next_state = ST_BINS;
                end
            end
`endif
            ST_BINS: begin
                w_cs   = 1'b1;
                w_rd   = 1'b1;
                w_addr = (16'(r_bin) << 2) | {14'd0, r_byte};
                if (r_phase && w_last_byte) begin
                    w_next_state = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // Bus stays idle while the word waits for the consumer
                if (out_ready) begin
                    w_next_state = w_last_bin ? ST_RELEASE : ST_BINS;
                end
            end
            ST_RELEASE: begin
                w_cs         = 1'b1;
                w_wr         = 1'b1;
                w_addr       = c_CTRL_ADDR;
                w_wdata      = c_LOCK_CLR;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Byte sequencing, word assembly, bin counter and status/done flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase      <= 1'b0;
            r_byte       <= 2'd0;
            r_bin        <= '0;
            r_word       <= 32'd0;
            r_status_ok  <= 1'b0;
            r_post_reset <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_LOCK: begin
                    r_phase <= 1'b0;
                    r_byte  <= 2'd0;
                    r_bin   <= '0;
                end
                ST_STATUS: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_status_ok <= readdata[0];
                    end
                end
`ifdef SFFT_READER_TIMESTAMP_EN
                ST_TIME: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_byte <= r_byte + 2'd1;
                    end
                end
`endif
                ST_BINS: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        // Ascending bytes shift in from the top: little-endian
                        r_byte <= r_byte + 2'd1;
                        r_word <= {readdata, r_word[31:8]};
                    end
                end
                ST_EMIT: begin
                    if (w_handshake) begin
                        r_bin <= w_last_bin ? '0 : r_bin + IDX_W'(1);
                    end
                end
                ST_RELEASE: begin
                    r_post_reset <= 1'b0;
                    if (!r_post_reset) begin
                        r_done  <= 1'b1;
                        r_error <= ~r_status_ok;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SFFT_READER_TIMESTAMP_EN
    logic [23:0] r_time_acc;
    logic [31:0] r_frame_time;

    // Timer bytes collect in a holding register; frame_time moves only once
    // the fourth byte is in so it never shows a half-updated value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_time_acc   <= 24'd0;
            r_frame_time <= 32'd0;
        end else if ((r_state == ST_TIME) && r_phase) begin
            if (w_last_byte) begin
                r_frame_time <= {readdata, r_time_acc};
            end else begin
                r_time_acc <= {readdata, r_time_acc[23:8]};
            end
        end
    end

    assign frame_time = r_frame_time;
`else
    assign frame_time = 32'd0;
`endif

    // Bus and status outputs are forced low for the whole reset interval,
    // even though the state register sits in RELEASE during it
    assign chipselect = reset & w_cs;
    assign read       = reset & w_rd;
    assign write      = reset & w_wr;
    assign address    = reset ? w_addr  : 16'h0000;
    assign writedata  = reset ? w_wdata : 8'h00;
    assign out_valid  = reset & (r_state == ST_EMIT);
    assign busy       = reset & (r_state != ST_IDLE);
    assign out_data   = r_word;
    assign out_index  = r_bin;
    assign done       = r_done;
    assign error      = r_error;

endmodule

`default_nettype wire
